// File: rtl/sd_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sd_req_arbiter_pkg
//   Shared definitions for the SD request arbiter: FSM state encodings
//   (3-bit, legacy-compatible localparams), operation encoding and a small
//   round-robin pointer helper.
// ---------------------------------------------------------------------------
package sd_req_arbiter_pkg;

    // Arbiter FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAITBSY = 3'd2;
    localparam logic [2:0] ST_XFER    = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

    // Operation encoding
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Width of the shared watchdog / issue counter
    localparam int CNT_W = 25;

    // Next round-robin position after index v among n clients
    function automatic int wrap_inc(input int v, input int n);
        if (v + 1 >= n) begin
            return 0;
        end else begin
            return v + 1;
        end
    endfunction

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector: returns the first set request at or
//   after the pointer, wrapping around.
//   Ports:
//     req       in  NREQ  pending request vector
//     ptr       in  PW    round-robin start position (< NREQ)
//     pick_oh   out NREQ  one-hot selected client (zero if none pending)
//     pick_idx  out PW    index of selected client
//     pick_any  out 1     at least one request pending
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick_oh,
    output logic [PW-1:0]   pick_idx,
    output logic            pick_any
);

    // Scan NREQ positions starting at ptr; the first hit wins
    always_comb begin : pick_scan
        int cand;
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        cand     = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ((int'(ptr) + i) >= NREQ) ? (int'(ptr) + i - NREQ) : (int'(ptr) + i);
            if (!pick_any && req[cand]) begin
                pick_any      = 1'b1;
                pick_oh[cand] = 1'b1;
                pick_idx      = PW'(cand);
            end else begin
                pick_any = pick_any;
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// ---------------------------------------------------------------------------
// sd_req_arbiter
//   Shares one sd_rw sector engine between NREQ clients. A round-robin pick
//   selects one pending read/write, the arbiter issues rstart/wstart with the
//   client's sector, routes the engine byte stream to/from the granted client
//   only, and returns a one-cycle done pulse with an error flag.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     req_rd/req_wr   in  NREQ     level requests, held until done
//     req_sector      in  32*NREQ  per-client sector
//     cl_inbyte       in  8*NREQ   per-client write byte
//     cl_grant        out NREQ     one-hot owner (zero when idle)
//     cl_done         out NREQ     completion pulse
//     cl_err          out 1        error flag, valid with cl_done
//     cl_outen        out NREQ     sd_outen gated to the owner
//     cl_outaddr/cl_outbyte        engine read stream, broadcast
//     card_ready      out 1        idle and engine not busy
//     sd_rstart/sd_wstart/sd_sector/sd_inbyte   to sd_rw
//     sd_rbusy/sd_rdone/sd_outen/sd_outaddr/sd_outbyte  from sd_rw
// ---------------------------------------------------------------------------
module sd_req_arbiter
    import sd_req_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 2**24,
    parameter int ISS_CYC = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_rd,
    input  logic [NREQ-1:0]     req_wr,
    input  logic [32*NREQ-1:0]  req_sector,
    input  logic [8*NREQ-1:0]   cl_inbyte,
    output logic [NREQ-1:0]     cl_grant,
    output logic [NREQ-1:0]     cl_done,
    output logic                cl_err,
    output logic [NREQ-1:0]     cl_outen,
    output logic [8:0]          cl_outaddr,
    output logic [7:0]          cl_outbyte,
    output logic                card_ready,
    output logic                sd_rstart,
    output logic                sd_wstart,
    output logic [31:0]         sd_sector,
    output logic [7:0]          sd_inbyte,
    input  logic                sd_rbusy,
    input  logic                sd_rdone,
    input  logic                sd_outen,
    input  logic [8:0]          sd_outaddr,
    input  logic [7:0]          sd_outbyte
);

    localparam int PW = $clog2(NREQ);
    // Counter holds "cycles since issue"; these are the values at which the
    // FSM gives up, so the done pulse lands ISS_CYC+2 / TMO_CYC after start.
    localparam logic [CNT_W-1:0] ISS_LIM = CNT_W'(ISS_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC - 1);

    logic [2:0]       state_r;
    logic [NREQ-1:0]  grant_r;
    logic [PW-1:0]    grant_idx_r;
    logic [PW-1:0]    rr_ptr_r;
    logic [31:0]      sector_r;
    logic             rstart_r;
    logic             wstart_r;
    logic [NREQ-1:0]  done_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;
    logic             rdone_seen_r;

    logic [NREQ-1:0]  pend_s;
    logic [NREQ-1:0]  pick_oh_s;
    logic [PW-1:0]    pick_idx_s;
    logic             pick_any_s;
    logic             pick_op_s;
    logic [7:0]       inbyte_s;

    assign pend_s    = req_rd | req_wr;
    // Read wins when a client raises both
    assign pick_op_s = req_rd[pick_idx_s] ? OP_RD : OP_WR;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req      (pend_s),
        .ptr      (rr_ptr_r),
        .pick_oh  (pick_oh_s),
        .pick_idx (pick_idx_s),
        .pick_any (pick_any_s)
    );

    // Arbitration FSM, watchdog and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            grant_idx_r  <= '0;
            rr_ptr_r     <= '0;
            sector_r     <= 32'h0000_0000;
            rstart_r     <= 1'b0;
            wstart_r     <= 1'b0;
            done_r       <= '0;
            err_r        <= 1'b0;
            cnt_r        <= '0;
            rdone_seen_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= '0;
                    err_r  <= 1'b0;
                    // An engine still busy (init, or left over from an abort) blocks grants
                    if (!sd_rbusy && pick_any_s) begin
                        grant_r     <= pick_oh_s;
                        grant_idx_r <= pick_idx_s;
                        sector_r    <= req_sector[32*pick_idx_s +: 32];
                        rstart_r    <= (pick_op_s == OP_RD);
                        wstart_r    <= (pick_op_s == OP_WR);
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    rstart_r     <= 1'b0;
                    wstart_r     <= 1'b0;
                    cnt_r        <= CNT_W'(1);
                    rdone_seen_r <= 1'b0;
                    state_r      <= ST_WAITBSY;
                end
                ST_WAITBSY: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (sd_rbusy) begin
                        state_r <= ST_XFER;
                    end else if (cnt_r >= ISS_LIM) begin
                        done_r  <= grant_r;
                        err_r   <= 1'b1;
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_WAITBSY;
                    end
                end
                ST_XFER: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (sd_rdone) begin
                        rdone_seen_r <= 1'b1;
                    end else begin
                        rdone_seen_r <= rdone_seen_r;
                    end
                    // sd_rw returns to ready without rdone on a failed write
                    if (!sd_rbusy) begin
                        done_r  <= grant_r;
                        err_r   <= ~(rdone_seen_r | sd_rdone);
                        state_r <= ST_FIN;
                    end else if (cnt_r >= TMO_LIM) begin
                        done_r  <= grant_r;
                        err_r   <= 1'b1;
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_XFER;
                    end
                end
                ST_FIN: begin
                    done_r   <= '0;
                    err_r    <= 1'b0;
                    grant_r  <= '0;
                    rr_ptr_r <= PW'(wrap_inc(int'(grant_idx_r), NREQ));
                    state_r  <= ST_IDLE;
                end
                default: begin
                    done_r   <= '0;
                    err_r    <= 1'b0;
                    grant_r  <= '0;
                    rstart_r <= 1'b0;
                    wstart_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-byte mux on the registered grant; zero-latency against sd_outaddr
    always_comb begin
        inbyte_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            inbyte_s = inbyte_s | (cl_inbyte[8*i +: 8] & {8{grant_r[i]}});
        end
    end

    assign cl_grant   = grant_r;
    assign cl_done    = done_r;
    assign cl_err     = err_r;
    assign cl_outen   = {NREQ{sd_outen}} & grant_r;
    assign cl_outaddr = sd_outaddr;
    assign cl_outbyte = sd_outbyte;
    assign card_ready = (state_r == ST_IDLE) && !sd_rbusy;
    assign sd_rstart  = rstart_r;
    assign sd_wstart  = wstart_r;
    assign sd_sector  = sector_r;
    assign sd_inbyte  = inbyte_s;

endmodule
